// File: rtl/i2c_slave.sv
// i2c_slave: I2C target with byte register file; optional pointer auto-increment via I2C_SLAVE_AUTO_INC_EN
module i2c_slave #(
   parameter logic [6:0] DEV_ADDR = 7'h50,
   parameter int         NUM_REGS = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       SCL_in,
   input  logic       SDA_in,
   output logic       SDA_out,
   output logic [7:0] Data_out,
   output logic [7:0] Data_addr,
   output logic       Data_valid,
   output logic       busy
);
   localparam int AW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
   typedef enum logic [3:0] {IDLE, DEV, ACK_DEV, REG, ACK_REG, WR, ACK_WR, RD, RD_ACK, WAIT} state_t;
   state_t     state;
   logic [2:0] scl_s, sda_s, cnt;
   logic [7:0] shreg, rd_sh, ptr, ptr_inc, byte_in, cur;
   logic       ph, scl_rise, scl_fall, start, stop;
   logic [7:0] regs [NUM_REGS];
   assign scl_rise = scl_s[1] & ~scl_s[2];
   assign scl_fall = ~scl_s[1] & scl_s[2];
   assign start    = scl_s[1] & scl_s[2] & ~sda_s[1] & sda_s[2];
   assign stop     = scl_s[1] & scl_s[2] & sda_s[1] & ~sda_s[2];
   assign byte_in  = {shreg[6:0], sda_s[1]};
   assign cur      = regs[ptr[AW-1:0]];
`ifdef I2C_SLAVE_AUTO_INC_EN
   assign ptr_inc  = (ptr == 8'(NUM_REGS - 1)) ? 8'd0 : ptr + 8'd1;
`else
   assign ptr_inc  = ptr;
`endif
   // two-flop synchronizers plus one history flop for edge detection
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         scl_s <= '1;
         sda_s <= '1;
      end else begin
         scl_s <= {scl_s[1:0], SCL_in};
         sda_s <= {sda_s[1:0], SDA_in};
      end
   // protocol FSM: bits sampled on SCL rise, SDA drive changed on SCL fall
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         ph         <= 1'b0;
         shreg      <= '0;
         rd_sh      <= '0;
         ptr        <= '0;
         SDA_out    <= 1'b1;
         Data_out   <= '0;
         Data_addr  <= '0;
         Data_valid <= 1'b0;
         busy       <= 1'b0;
         regs       <= '{default: '0};
      end else begin
         Data_valid <= 1'b0;
         if (stop) begin
            state   <= IDLE;
            SDA_out <= 1'b1;
            busy    <= 1'b0;
            cnt     <= '0;
         end else if (start) begin
            state   <= DEV;
            SDA_out <= 1'b1;
            cnt     <= '0;
         end else if (scl_rise) begin
            case (state)
               DEV, REG, WR: begin
                  shreg <= byte_in;
                  cnt   <= cnt + 3'd1;
                  if (cnt == 3'd7) begin
                     ph    <= 1'b0;
                     state <= state == DEV ? ACK_DEV : state == REG ? ACK_REG : ACK_WR;
                     if (state == WR) begin
                        regs[ptr[AW-1:0]] <= byte_in;
                        Data_out          <= byte_in;
                        Data_addr         <= ptr;
                        Data_valid        <= 1'b1;
                     end
                  end
               end
               RD_ACK:
                  if (sda_s[1]) state <= WAIT;
                  else begin
                     ph  <= 1'b1;
                     ptr <= ptr_inc;
                  end
               default: ;
            endcase
         end else if (scl_fall) begin
            case (state)
               ACK_DEV:
                  if (!ph) begin
                     if (shreg[7:1] == DEV_ADDR) begin
                        SDA_out <= 1'b0;
                        busy    <= 1'b1;
                        ph      <= 1'b1;
                     end else state <= WAIT;
                  end else if (shreg[0]) begin
                     state   <= RD;
                     SDA_out <= cur[7];
                     rd_sh   <= {cur[6:0], 1'b0};
                     cnt     <= '0;
                  end else begin
                     state   <= REG;
                     SDA_out <= 1'b1;
                  end
               ACK_REG:
                  if (!ph) begin
                     if ({1'b0, shreg} < 9'(NUM_REGS)) begin
                        ptr     <= shreg;
                        SDA_out <= 1'b0;
                        ph      <= 1'b1;
                     end else state <= WAIT;
                  end else begin
                     state   <= WR;
                     SDA_out <= 1'b1;
                  end
               ACK_WR:
                  if (!ph) begin
                     SDA_out <= 1'b0;
                     ph      <= 1'b1;
                  end else begin
                     state   <= WR;
                     SDA_out <= 1'b1;
                     ptr     <= ptr_inc;
                  end
               RD: begin
                  cnt <= cnt + 3'd1;
                  if (cnt == 3'd7) begin
                     SDA_out <= 1'b1;
                     ph      <= 1'b0;
                     state   <= RD_ACK;
                  end else begin
                     SDA_out <= rd_sh[7];
                     rd_sh   <= {rd_sh[6:0], 1'b0};
                  end
               end
               RD_ACK:
                  if (ph) begin
                     state   <= RD;
                     SDA_out <= cur[7];
                     rd_sh   <= {cur[6:0], 1'b0};
                     cnt     <= '0;
                  end
               default: ;
            endcase
         end
      end
endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bit-banged I2C master exercising i2c_slave writes, reads, NACKs, aborts and reset
module tb_i2c_slave;
   logic       clk = 1'b0, rst_n = 1'b0, scl = 1'b1, sda_m = 1'b1;
   logic       sda_out, dv, busy, sda_bus;
   logic [7:0] dout, daddr;
   int         n_cmp = 0, n_err = 0, dv_cnt = 0;
   assign sda_bus = sda_m & sda_out;
   i2c_slave dut (
      .clk(clk), .rst(rst_n), .SCL_in(scl), .SDA_in(sda_bus), .SDA_out(sda_out),
      .Data_out(dout), .Data_addr(daddr), .Data_valid(dv), .busy(busy)
   );
   always #5 clk = ~clk;
   always @(negedge clk) if (dv) dv_cnt++;
   typedef struct {
      logic [7:0] dev, rg, dat;
      logic       ack_dev, ack_reg, exp_dv;
   } vec_t;
   vec_t vt [6];
   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic wt(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic wbit(input logic b);
      wt(3); sda_m = b; wt(7); scl = 1'b1; wt(10); scl = 1'b0;
   endtask
   task automatic rbit(output logic b);
      wt(3); sda_m = 1'b1; wt(7); scl = 1'b1; wt(5); b = sda_bus; wt(5); scl = 1'b0;
   endtask
   task automatic i2c_start;
      wt(3); sda_m = 1'b1; wt(7); scl = 1'b1; wt(10); sda_m = 1'b0; wt(10); scl = 1'b0;
   endtask
   task automatic i2c_stop;
      wt(3); sda_m = 1'b0; wt(7); scl = 1'b1; wt(10); sda_m = 1'b1; wt(10);
   endtask
   task automatic wr_byte(input logic [7:0] b, output logic ack);
      logic a;
      for (int i = 7; i >= 0; i--) wbit(b[i]);
      rbit(a);
      ack = ~a;
   endtask
   task automatic rd_reg(input logic [7:0] r, input int n, output logic [15:0] v, output logic bsy, output logic rel);
      logic a, b;
      v = '0;
      i2c_start; wr_byte(8'hA0, a); wr_byte(r, a);
      i2c_start; bsy = busy;
      wr_byte(8'hA1, a);
      for (int k = 0; k < n; k++) begin
         for (int i = 0; i < 8; i++) begin
            rbit(b);
            v = {v[14:0], b};
         end
         wbit(k == n - 1);
      end
      wt(5); rel = sda_out;
      i2c_stop; wt(5);
   endtask
   initial begin
      logic a, bsy, rel, b;
      logic [15:0] v;
      int d0;
      vt[0] = '{8'hA0, 8'h03, 8'hA5, 1'b1, 1'b1, 1'b1};
      vt[1] = '{8'hA2, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
      vt[2] = '{8'hA0, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0};
      vt[3] = '{8'hA0, 8'h0F, 8'h3C, 1'b1, 1'b1, 1'b1};
      vt[4] = '{8'hA0, 8'h00, 8'h5A, 1'b1, 1'b1, 1'b1};
      vt[5] = '{8'hA0, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0};
      wt(3);
      chk("rst_sda", 16'(sda_out), 16'h1);
      chk("rst_busy", 16'(busy), 16'h0);
      chk("rst_dout", 16'(dout), 16'h0);
      chk("rst_daddr", 16'(daddr), 16'h0);
      chk("rst_dv", 16'(dv), 16'h0);
      rst_n = 1'b1; wt(5);
      for (int i = 0; i < 6; i++) begin
         d0 = dv_cnt;
         i2c_start;
         wr_byte(vt[i].dev, a);
         chk($sformatf("v%0d_ack_dev", i), 16'(a), 16'(vt[i].ack_dev));
         chk($sformatf("v%0d_busy_on", i), 16'(busy), 16'(vt[i].ack_dev));
         if (a) begin
            wr_byte(vt[i].rg, a);
            chk($sformatf("v%0d_ack_reg", i), 16'(a), 16'(vt[i].ack_reg));
            if (a) begin
               wr_byte(vt[i].dat, a);
               chk($sformatf("v%0d_ack_dat", i), 16'(a), 16'h1);
            end
         end
         i2c_stop; wt(5);
         chk($sformatf("v%0d_busy_off", i), 16'(busy), 16'h0);
         chk($sformatf("v%0d_dv_cnt", i), 16'(dv_cnt - d0), 16'(vt[i].exp_dv));
         if (vt[i].exp_dv) begin
            chk($sformatf("v%0d_dout", i), 16'(dout), 16'(vt[i].dat));
            chk($sformatf("v%0d_daddr", i), 16'(daddr), 16'(vt[i].rg));
         end
      end
      rd_reg(8'h03, 1, v, bsy, rel);
      chk("rd03", v, 16'h00A5);
      chk("rd_busy_rstart", 16'(bsy), 16'h1);
      chk("rd_nack_release", 16'(rel), 16'h1);
      rd_reg(8'h0F, 1, v, bsy, rel);
      chk("rd0f", v, 16'h003C);
      d0 = dv_cnt;
      i2c_start; wr_byte(8'hA0, a); wr_byte(8'h05, a);
      wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b0);
      i2c_stop; wt(5);
      chk("abort_dv", 16'(dv_cnt - d0), 16'h0);
      chk("abort_busy", 16'(busy), 16'h0);
      i2c_start; wr_byte(8'hA0, a);
      chk("abort_next_ack", 16'(a), 16'h1);
      wr_byte(8'h05, a); wr_byte(8'h77, a);
      i2c_stop; wt(5);
      chk("abort_next_dv", 16'(dv_cnt - d0), 16'h1);
      rd_reg(8'h05, 1, v, bsy, rel);
      chk("rd05", v, 16'h0077);
      d0 = dv_cnt;
      i2c_start; wr_byte(8'hA0, a); wr_byte(8'h0F, a);
      wr_byte(8'h11, a); wr_byte(8'h22, a); wr_byte(8'h33, a);
      chk("multi_ack", 16'(a), 16'h1);
      i2c_stop; wt(5);
      chk("multi_dv", 16'(dv_cnt - d0), 16'h3);
      chk("multi_dout", 16'(dout), 16'h33);
`ifdef I2C_SLAVE_AUTO_INC_EN
      chk("multi_daddr", 16'(daddr), 16'h01);
      rd_reg(8'h0F, 2, v, bsy, rel);
      chk("rd0f_2", v, 16'h1122);
      rd_reg(8'h00, 1, v, bsy, rel);
      chk("rd00", v, 16'h0022);
      rd_reg(8'h01, 1, v, bsy, rel);
      chk("rd01", v, 16'h0033);
`else
      chk("multi_daddr", 16'(daddr), 16'h0F);
      rd_reg(8'h0F, 2, v, bsy, rel);
      chk("rd0f_2", v, 16'h3333);
      rd_reg(8'h00, 1, v, bsy, rel);
      chk("rd00", v, 16'h005A);
      rd_reg(8'h01, 1, v, bsy, rel);
      chk("rd01", v, 16'h0000);
`endif
      i2c_start; wr_byte(8'hA0, a); wr_byte(8'h03, a);
      i2c_start; wr_byte(8'hA1, a);
      rbit(b);
      chk("mid_bit7", 16'(b), 16'h1);
      wt(5);
      chk("mid_drive_low", 16'(sda_out), 16'h0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_release", 16'(sda_out), 16'h1);
      chk("mid_rst_busy", 16'(busy), 16'h0);
      chk("mid_rst_dout", 16'(dout), 16'h0);
      wt(2);
      rst_n = 1'b1; scl = 1'b1; sda_m = 1'b1;
      wt(20);
      rd_reg(8'h03, 1, v, bsy, rel);
      chk("post_rst_rd03", v, 16'h0000);
      rd_reg(8'h0F, 1, v, bsy, rel);
      chk("post_rst_rd0f", v, 16'h0000);
      rd_reg(8'h05, 1, v, bsy, rel);
      chk("post_rst_rd05", v, 16'h0000);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C target (responder) for the team's I2C master; answers one fixed 7-bit device address.
- Holds an internal byte-wide register file.
- Supports master writes (register pointer, then data) and master reads (repeated START, then data from the pointer).
- Open-drain SDA modelled as SDA_in plus SDA_out (1 = release, 0 = pull low). SCL is input only; no clock stretching.

Parameters:
- DEV_ADDR, 7'h50, 7-bit device address this block answers.
- NUM_REGS, 16, number of 8-bit registers (1..256); register addresses >= NUM_REGS are out of range.

Ports:
- clk  input  1  system clock, at least 8x SCL frequency.
- rst  input  1  asynchronous active-low reset.
- SCL_in  input  1  bus SCL level.
- SDA_in  input  1  bus SDA level.
- SDA_out  output  1  SDA drive: 0 = pull low, 1 = release.
- Data_out  output  8  last byte written by the master.
- Data_addr  output  8  register address of Data_out.
- Data_valid  output  1  one-clk pulse per accepted write byte.
- busy  output  1  high from an address-matched START until STOP.

Behaviour:
- Reset: asynchronous; asserting rst low releases SDA_out=1 in the same instant. Also clears Data_out, Data_addr, Data_valid, busy, register pointer and all registers to 0, and puts the FSM in IDLE. Reset mid-transfer aborts it with no partial write.
- Input sync: SCL_in and SDA_in each pass through 2 flops plus one history flop. Edges are detected on the synchronized signals only.
- START: synchronized SCL high while SDA falls. STOP: SCL high while SDA rises.
- Data sampling and drive timing:
  - Incoming bits are sampled on the synchronized SCL rising edge, MSB first.
  - SDA_out changes only on the clk after a synchronized SCL falling edge, which is 3 clk after the SCL_in fall.
- States:
  - IDLE: wait for START.
  - DEV: shift 8 bits (7 address bits + R/W).
  - ACK_DEV:
    - On match, drive 0 from the next SCL fall to the following SCL fall.
    - On mismatch, stay released and go to WAIT.
  - REG: shift the 8-bit register address.
  - ACK_REG: if the address is < NUM_REGS, load the pointer and ACK; otherwise NACK and go to WAIT.
  - WR: shift 8 data bits.
  - ACK_WR: write the register, ACK, return to WR.
  - RD: drive the 8 bits of reg[pointer], MSB first; the first bit is driven on the SCL fall that ends the ACK_DEV slot.
  - RD_ACK: release SDA and sample the master's bit on SCL rise.
    - 0 (ACK): next byte.
    - 1 (NACK): WAIT.
  - WAIT: SDA released; ignore everything until START or STOP.
- R/W bit: 0 selects REG after ACK_DEV; 1 selects RD.
- Data_valid:
  - Pulses exactly 1 clk, on the clk after the 8th WR bit is sampled.
  - Data_out and Data_addr update in that same clk.
  - The register file is written in that same clk.
- STOP in any state: IDLE, SDA_out=1, busy=0. A partially shifted byte is discarded.
- START in any non-IDLE state (repeated START): go to DEV, clear the bit counter, keep the pointer. This enables write-pointer-then-read.
- busy: set on the DEV-match ACK, cleared on STOP or reset; it stays high across a repeated START.
- Bit counter: 3 bits, wraps 7->0 at each byte boundary.
- WR after pointer load with AUTO_INC disabled: repeated data bytes all overwrite the same register.

Optional Feature:
- Macro: I2C_SLAVE_AUTO_INC_EN.
- Defined:
  - The pointer increments after every ACK_WR.
  - The pointer increments after every RD_ACK=ACK.
  - The pointer wraps NUM_REGS-1 -> 0.
- Undefined: the pointer stays fixed for the whole transaction; multi-byte reads return the same register repeatedly.

Test Plan:
- Write: START, 0xA0 (0x50+W), reg 0x03, data 0xA5, STOP -> ACK on all three bytes; Data_valid pulses once with Data_addr=0x03 and Data_out=0xA5; busy falls after STOP.
- Read: START, 0xA0, 0x03, repeated START, 0xA1, master NACK, STOP -> slave drives 0xA5 MSB-first on SDA_out; SDA_out=1 after NACK; busy stays high through the repeated START.
- Wrong address / out of range:
  - Address 0x51 -> SDA_out stays 1 in the ACK slot; no Data_valid; busy=0.
  - Register 0x10 with NUM_REGS=16 -> NACK after the register byte.
- Abort: STOP after 4 bits of a data byte -> no Data_valid, FSM in IDLE; the next transaction to 0x50 is ACKed normally.
- Reset mid-read: pull rst low while SDA_out=0 in RD -> SDA_out=1 immediately; all registers read back 0x00 afterwards.
- Auto-increment (macro defined): write 0x11, 0x22, 0x33 starting at reg 0x0F with NUM_REGS=16 -> regs 0x0F=0x11, 0x00=0x22, 0x01=0x33. Undefined: reg 0x0F=0x33 only.
